mem_loader: RTL and testbench

- Boot-time loader that fills the instruction and data BRAMs from a 32-bit valid/ready word stream.
- Holds the core stalled until loading is complete, then hands the BRAM write ports over to the CPU datapath.
- Sits between a host stream source (UART/JTAG bridge or bench driver) and the bram32 write ports.
- Generalises single-region preload to NUM_REGIONS memories, with framed commands, error detection and reload support.

---
 rtl/mem_loader_pkg.sv | 36 +++
 rtl/mem_loader_xor_accum.sv | 21 ++
 rtl/mem_loader.sv | 136 +++++++++++++
 tb/tb_mem_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the boot-time BRAM loader: frame constants, header field helpers, FSM states.
// The CHECK state exists only when MEM_LOADER_CHECKSUM_EN is defined.
package mem_loader_pkg;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;
  localparam logic [7:0] LOADER_GO_ID = 8'hFF;

  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_ID_LSB    = 16;
  localparam int HDR_CNT_LSB   = 0;
  localparam int HDR_CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BASE,
    ST_DATA,
    ST_DONE,
    ST_ERROR
`ifdef MEM_LOADER_CHECKSUM_EN
    , ST_CHECK
`endif
  } loader_state_t;

  function automatic logic [7:0] hdr_magic(input logic [31:0] word);
    return word[HDR_MAGIC_LSB +: 8];
  endfunction

  function automatic logic [7:0] hdr_id(input logic [31:0] word);
    return word[HDR_ID_LSB +: 8];
  endfunction

  function automatic logic [HDR_CNT_W-1:0] hdr_count(input logic [31:0] word);
    return word[HDR_CNT_LSB +: HDR_CNT_W];
  endfunction

endpackage

// File: rtl/mem_loader_xor_accum.sv
// Running XOR of payload words, cleared at every frame header; used for the optional frame checksum.
module loader_xor_accum #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] acc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Boot loader: parses framed words from a valid/ready stream into per-region BRAM writes, then releases the CPU.
// Define MEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word on every frame.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int NUM_REGIONS = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic                              reload,
  output logic [NUM_REGIONS*ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0]             w_dat,
  output logic [NUM_REGIONS-1:0]            w_enb,
  output logic                              cpu_stall,
  output logic                              init_done,
  output logic                              err
);

  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  loader_state_t         state;
  logic [RW-1:0]         region;
  logic [HDR_CNT_W-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic                  accept;
  logic [7:0]            f_magic;
  logic [7:0]            f_id;
  logic [HDR_CNT_W-1:0]  f_count;

  assign f_magic = hdr_magic(s_data[31:0]);
  assign f_id    = hdr_id(s_data[31:0]);
  assign f_count = hdr_count(s_data[31:0]);
  assign accept  = s_valid && s_ready;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] xor_sum;

  loader_xor_accum #(.DATA_WIDTH(DATA_WIDTH)) u_xor (
    .clk (clk),
    .rst (rst),
    .clr (accept && (state == ST_IDLE)),
    .en  (accept && (state == ST_DATA)),
    .din (s_data),
    .acc (xor_sum)
  );

  localparam loader_state_t AFTER_PAYLOAD = ST_CHECK;
`else
  localparam loader_state_t AFTER_PAYLOAD = ST_IDLE;
`endif

  // Gated by rst so the source sees no acceptance during the reset cycle.
  always_comb begin
    s_ready = 1'b0;
    unique case (state)
      ST_IDLE, ST_BASE, ST_DATA: s_ready = !rst;
`ifdef MEM_LOADER_CHECKSUM_EN
      ST_CHECK:                  s_ready = !rst;
`endif
      default:                   s_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      region    <= '0;
      remaining <= '0;
      addr_cnt  <= '0;
      w_addr    <= '0;
      w_dat     <= '0;
      w_enb     <= '0;
      cpu_stall <= 1'b1;
      init_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      w_enb <= '0;
      unique case (state)
        ST_IDLE: if (accept) begin
          if (f_magic != LOADER_MAGIC) begin
            state <= ST_ERROR;
            err   <= 1'b1;
          end else if (f_id == LOADER_GO_ID) begin
            state     <= ST_DONE;
            cpu_stall <= 1'b0;
            init_done <= 1'b1;
          end else if (int'(f_id) >= NUM_REGIONS) begin
            state <= ST_ERROR;
            err   <= 1'b1;
          end else begin
            region    <= f_id[RW-1:0];
            remaining <= f_count;
            state     <= ST_BASE;
          end
        end
        ST_BASE: if (accept) begin
          addr_cnt <= s_data[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(3);
          state    <= (remaining == '0) ? AFTER_PAYLOAD : ST_DATA;
        end
        // Address wraps naturally at the counter width.
        ST_DATA: if (accept) begin
          w_enb     <= NUM_REGIONS'(1) << region;
          w_dat     <= s_data;
          w_addr[int'(region)*ADDR_WIDTH +: ADDR_WIDTH] <= addr_cnt;
          addr_cnt  <= addr_cnt + ADDR_WIDTH'(4);
          remaining <= remaining - HDR_CNT_W'(1);
          if (remaining == HDR_CNT_W'(1)) begin
            state <= AFTER_PAYLOAD;
          end
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        ST_CHECK: if (accept) begin
          if (s_data != xor_sum) begin
            state <= ST_ERROR;
            err   <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
`endif
        ST_DONE: if (reload) begin
          state     <= ST_IDLE;
          cpu_stall <= 1'b1;
          init_done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: a frame-level reference model checks every output each cycle.
// Exercises the checksum path as well when MEM_LOADER_CHECKSUM_EN is defined.
module tb_mem_loader;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  s_data;
  logic           s_valid;
  logic           s_ready;
  logic           reload;
  logic [NR*AW-1:0] w_addr;
  logic [DW-1:0]  w_dat;
  logic [NR-1:0]  w_enb;
  logic           cpu_stall;
  logic           init_done;
  logic           err;

  mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGIONS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .reload    (reload),
    .w_addr    (w_addr),
    .w_dat     (w_dat),
    .w_enb     (w_enb),
    .cpu_stall (cpu_stall),
    .init_done (init_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit bubbles_on = 1'b0;

  // Reference model: what the stream has loaded so far, frame by frame
  bit          m_done, m_err, m_in_frame, m_need_base, m_need_chk;
  int          m_region, m_left;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_xsum;
  logic [NR-1:0] e_enb;
  logic [DW-1:0] e_dat;
  logic [NR*AW-1:0] e_addr;

  int          wr_enb_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_dat_q[$];
  logic [DW-1:0] frame_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit chk_enabled();
`ifdef MEM_LOADER_CHECKSUM_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Model step at each edge, then compare DUT outputs shortly after it
  always @(posedge clk) begin
    if (rst) begin
      m_done = 0; m_err = 0; m_in_frame = 0; m_need_base = 0; m_need_chk = 0;
      m_left = 0; m_region = 0; m_addr = '0; m_xsum = '0;
      e_enb = '0; e_dat = '0; e_addr = '0;
    end else begin
      e_enb = '0;
      if (s_valid && !m_done && !m_err) begin
        if (!m_in_frame) begin
          if (s_data[31:24] != 8'hA5) m_err = 1;
          else if (s_data[23:16] == 8'hFF) m_done = 1;
          else if (int'(s_data[23:16]) >= NR) m_err = 1;
          else begin
            m_in_frame = 1; m_need_base = 1;
            m_region = int'(s_data[23:16]); m_left = int'(s_data[15:0]); m_xsum = '0;
          end
        end else if (m_need_base) begin
          m_addr = s_data[AW-1:0] & 10'h3FC;
          m_need_base = 0;
          if (m_left == 0) begin
            if (chk_enabled()) m_need_chk = 1; else m_in_frame = 0;
          end
        end else if (m_left > 0) begin
          e_enb = NR'(1) << m_region;
          e_dat = s_data;
          e_addr[m_region*AW +: AW] = m_addr;
          m_addr = m_addr + 10'd4;
          m_xsum = m_xsum ^ s_data;
          m_left--;
          if (m_left == 0) begin
            if (chk_enabled()) m_need_chk = 1; else m_in_frame = 0;
          end
        end else if (m_need_chk) begin
          if (s_data != m_xsum) m_err = 1;
          m_need_chk = 0; m_in_frame = 0;
        end
      end else if (m_done && reload) begin
        m_done = 0;
      end
    end
    #1;
    checkOutput("s_ready", 32'(s_ready), 32'(!rst && !m_done && !m_err));
    checkOutput("cpu_stall", 32'(cpu_stall), 32'(!m_done));
    checkOutput("init_done", 32'(init_done), 32'(m_done));
    checkOutput("err", 32'(err), 32'(m_err));
    checkOutput("w_enb", 32'(w_enb), 32'(e_enb));
    checkOutput("w_dat", w_dat, e_dat);
    checkOutput("w_addr", 32'(w_addr), 32'(e_addr));
    if (w_enb != '0) begin
      wr_enb_q.push_back(int'(w_enb));
      wr_addr_q.push_back(w_enb[1] ? w_addr[2*AW-1:AW] : w_addr[AW-1:0]);
      wr_dat_q.push_back(w_dat);
    end
  end

  task automatic applyStimulus(input logic [31:0] word);
    if (bubbles_on && $urandom_range(0, 3) == 0) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = word;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic sendFrame(input int id, input logic [31:0] base);
    logic [31:0] x;
    x = '0;
    applyStimulus({8'hA5, 8'(id), 16'(frame_q.size())});
    applyStimulus(base);
    foreach (frame_q[i]) begin
      applyStimulus(frame_q[i]);
      x = x ^ frame_q[i];
    end
    if (chk_enabled()) applyStimulus(x);
  endtask

  task automatic doReset();
    rst = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_s_ready", 32'(s_ready), 0);
    checkOutput("rst_w_enb", 32'(w_enb), 0);
    checkOutput("rst_w_addr", 32'(w_addr), 0);
    checkOutput("rst_w_dat", w_dat, 0);
    checkOutput("rst_cpu_stall", 32'(cpu_stall), 1);
    checkOutput("rst_init_done", 32'(init_done), 0);
    checkOutput("rst_err", 32'(err), 0);
    rst = 1'b0;
  endtask

  task automatic pulseReload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic clearLog();
    wr_enb_q.delete();
    wr_addr_q.delete();
    wr_dat_q.delete();
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; reload = 1'b0; s_data = '0;
    @(negedge clk);
    doReset();

    // Basic I-MEM load followed by GO
    clearLog();
    applyStimulus(32'hA5000003);
    applyStimulus(32'h00000000);
    applyStimulus(32'h11111111);
    applyStimulus(32'h22222222);
    applyStimulus(32'h33333333);
    if (chk_enabled()) applyStimulus(32'h00000000);
    applyStimulus(32'hA5FF0000);
    checkOutput("t1_wr_count", wr_enb_q.size(), 3);
    if (wr_enb_q.size() >= 3) begin
      checkOutput("t1_enb0", wr_enb_q[0], 1);
      checkOutput("t1_addr0", 32'(wr_addr_q[0]), 32'h000);
      checkOutput("t1_addr1", 32'(wr_addr_q[1]), 32'h004);
      checkOutput("t1_addr2", 32'(wr_addr_q[2]), 32'h008);
      checkOutput("t1_dat0", wr_dat_q[0], 32'h11111111);
      checkOutput("t1_dat2", wr_dat_q[2], 32'h33333333);
    end
    checkOutput("t1_init_done", 32'(init_done), 1);
    checkOutput("t1_cpu_stall", 32'(cpu_stall), 0);
    pulseReload();
    checkOutput("reload_cpu_stall", 32'(cpu_stall), 1);
    checkOutput("reload_init_done", 32'(init_done), 0);

    // Region 1 address wrap
    clearLog();
    frame_q = '{32'h000000AA, 32'h000000BB};
    sendFrame(1, 32'h000003FC);
    checkOutput("wrap_count", wr_enb_q.size(), 2);
    if (wr_enb_q.size() >= 2) begin
      checkOutput("wrap_enb", wr_enb_q[0], 2);
      checkOutput("wrap_addr0", 32'(wr_addr_q[0]), 32'h3FC);
      checkOutput("wrap_addr1", 32'(wr_addr_q[1]), 32'h000);
      checkOutput("wrap_dat1", wr_dat_q[1], 32'hBB);
    end

    // Empty frame then GO
    clearLog();
    frame_q.delete();
    sendFrame(0, 32'h00000010);
    applyStimulus(32'hA5FF0000);
    checkOutput("n0_no_write", wr_enb_q.size(), 0);
    checkOutput("n0_init_done", 32'(init_done), 1);
    pulseReload();

    // Reset in the middle of a payload, then a fresh frame
    applyStimulus(32'hA5000003);
    applyStimulus(32'h00000020);
    applyStimulus(32'hDEADBEEF);
    doReset();
    frame_q = '{32'h01234567, 32'h89ABCDEF};
    sendFrame(0, 32'h00000040);
    applyStimulus(32'hA5FF0000);
    checkOutput("fresh_init_done", 32'(init_done), 1);

    // Bad magic is sticky until rst
    doReset();
    applyStimulus(32'h5A000001);
    checkOutput("bad_err", 32'(err), 1);
    checkOutput("bad_s_ready", 32'(s_ready), 0);
    applyStimulus(32'hA5FF0000);
    pulseReload();
    checkOutput("bad_go_ignored", 32'(init_done), 0);
    checkOutput("bad_still_err", 32'(err), 1);
    doReset();

    // Region out of range
    applyStimulus(32'hA5020001);
    checkOutput("range_err", 32'(err), 1);
    doReset();

`ifdef MEM_LOADER_CHECKSUM_EN
    applyStimulus(32'hA5000002);
    applyStimulus(32'h00000000);
    applyStimulus(32'h0F0F0000);
    applyStimulus(32'h00F0F0FF);
    applyStimulus(32'h0FFFF0FF);
    applyStimulus(32'hA5FF0000);
    checkOutput("chk_good_done", 32'(init_done), 1);
    doReset();
    applyStimulus(32'hA5000002);
    applyStimulus(32'h00000000);
    applyStimulus(32'h0F0F0000);
    applyStimulus(32'h00F0F0FF);
    applyStimulus(32'h00000000);
    checkOutput("chk_bad_err", 32'(err), 1);
    doReset();
`endif

    // Randomised frames with bubbles, stray reloads, resets and bad headers
    bubbles_on = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        logic [7:0] mg;
        mg = 8'($urandom_range(0, 255));
        if (mg == 8'hA5) mg = 8'h5A;
        applyStimulus({mg, 24'($urandom)});
        doReset();
      end else if (r == 1) begin
        pulseReload();
      end else if (r == 2) begin
        applyStimulus(32'hA5000004);
        applyStimulus($urandom);
        applyStimulus($urandom);
        doReset();
      end else begin
        frame_q.delete();
        for (int k = 0; k < int'($urandom_range(0, 6)); k++) frame_q.push_back($urandom);
        sendFrame(int'($urandom_range(0, 1)), $urandom);
      end
      if (it % 8 == 7) begin
        applyStimulus(32'hA5FF0000);
        repeat (2) @(negedge clk);
        pulseReload();
      end
    end
    applyStimulus(32'hA5FF0000);
    @(negedge clk);
    checkOutput("final_init_done", 32'(init_done), 1);
    checkOutput("final_cpu_stall", 32'(cpu_stall), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
